si571_pll_supervisor: RTL

SI571_PLL_SUPERVISOR -- requirements
Module: si571_pll_supervisor

---
 rtl/si571_pll_supervisor.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/si571_pll_supervisor.sv
// si571_pll_supervisor
//   Supervises lock acquisition of the Si571 frequency-follower PLL. A run
//   waits for a valid reference, then drives the PLL phase detector while it
//   counts locked and unlocked measurement periods. The supervisor declares
//   lock, backs off (holdoff) and retries, or gives up with a fault once all
//   retries are used.
//
// Optional feature macro: SI571_PLL_SUPERVISOR_STATS_EN
//   When defined, adds lost_cnt_o, a saturating count of lock-loss events.
//
// Ports
//   clk_i         system clock; every register updates on its rising edge
//   rst_i         synchronous active-high reset
//   enable_i      run request; low forces IDLE
//   meas_stb_i    one-cycle pulse per reference measurement period
//   ref_val_i     reference frequency within tolerance (sampled on strobe)
//   lock_i        filtered PLL lock status (sampled on strobe)
//   clr_fault_i   leaves FAULT
//   pll_cfg_en_o  PLL phase-detector drive enable (ACQUIRE/LOCKED)
//   locked_o      declared lock
//   fault_o       acquisition retries exhausted
//   state_o       state code (0 IDLE,1 WAIT_REF,2 ACQUIRE,3 LOCKED,4 HOLDOFF,5 FAULT)
//   retry_cnt_o   retries used in the current acquisition sequence
//   lost_cnt_o    (STATS_EN only) lock-loss count, saturating at 16'hFFFF
module si571_pll_supervisor #(
  parameter int ACQ_TIMEOUT  = 16,
  parameter int LOCK_CONFIRM = 4,
  parameter int UNLOCK_TOL   = 2,
  parameter int MAX_RETRY    = 3,
  parameter int HOLDOFF      = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       meas_stb_i,
  input  logic       ref_val_i,
  input  logic       lock_i,
  input  logic       clr_fault_i,
  output logic       pll_cfg_en_o,
  output logic       locked_o,
  output logic       fault_o,
  output logic [2:0] state_o,
  output logic [3:0] retry_cnt_o
`ifdef SI571_PLL_SUPERVISOR_STATS_EN
  ,
  output logic [15:0] lost_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_REF = 3'd1,
    S_ACQUIRE  = 3'd2,
    S_LOCKED   = 3'd3,
    S_HOLDOFF  = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  // Each counter is sized to reach its parameter value without wrapping.
  localparam int CW = $clog2(LOCK_CONFIRM + 1);
  localparam int TW = $clog2(ACQ_TIMEOUT + 1);
  localparam int MW = $clog2(UNLOCK_TOL + 1);
  localparam int HW = $clog2(HOLDOFF + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] conf_q, conf_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [HW-1:0] ho_q, ho_d;
  logic [3:0]    retry_q, retry_d;

  always_comb begin
    state_d = state_q;
    conf_d  = conf_q;
    tmo_d   = tmo_q;
    miss_d  = miss_q;
    ho_d    = ho_q;
    retry_d = retry_q;
    case (state_q)
      S_IDLE: begin
        retry_d = '0;
        state_d = S_WAIT_REF;
      end
      S_WAIT_REF: begin
        if (meas_stb_i && ref_val_i) begin
          state_d = S_ACQUIRE;
          conf_d  = '0;
          tmo_d   = '0;
        end
      end
      S_ACQUIRE: begin
        if (meas_stb_i) begin
          if (!ref_val_i) begin
            // Reference dropped out: not the PLL's fault, no retry consumed.
            state_d = S_WAIT_REF;
          end else if (lock_i) begin
            conf_d = conf_q + CW'(1);
            if (int'(conf_q) + 1 >= LOCK_CONFIRM) begin
              state_d = S_LOCKED;
              retry_d = '0;
              miss_d  = '0;
            end
          end else begin
            conf_d = '0;
            tmo_d  = tmo_q + TW'(1);
            if (int'(tmo_q) + 1 >= ACQ_TIMEOUT) begin
              if (int'(retry_q) < MAX_RETRY) begin
                retry_d = retry_q + 4'd1;
                ho_d    = '0;
                state_d = S_HOLDOFF;
              end else begin
                state_d = S_FAULT;
              end
            end
          end
        end
      end
      S_LOCKED: begin
        if (meas_stb_i) begin
          miss_d = lock_i ? '0 : miss_q + MW'(1);
          if (!ref_val_i || (!lock_i && int'(miss_q) + 1 >= UNLOCK_TOL)) begin
            ho_d    = '0;
            state_d = S_HOLDOFF;
          end
        end
      end
      S_HOLDOFF: begin
        // Stay exactly HOLDOFF cycles; strobes are ignored here.
        if (int'(ho_q) + 1 >= HOLDOFF) state_d = S_WAIT_REF;
        else                           ho_d    = ho_q + HW'(1);
      end
      S_FAULT: begin
        if (clr_fault_i) begin
          state_d = S_IDLE;
          retry_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Dropping the run request wins over everything; retry clears with it so
    // every output reads zero on the IDLE edge.
    if (!enable_i) begin
      state_d = S_IDLE;
      retry_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      conf_q       <= '0;
      tmo_q        <= '0;
      miss_q       <= '0;
      ho_q         <= '0;
      retry_q      <= '0;
      pll_cfg_en_o <= 1'b0;
      locked_o     <= 1'b0;
      fault_o      <= 1'b0;
    end else begin
      state_q      <= state_d;
      conf_q       <= conf_d;
      tmo_q        <= tmo_d;
      miss_q       <= miss_d;
      ho_q         <= ho_d;
      retry_q      <= retry_d;
      // Outputs are decoded from the next state so they land with it.
      pll_cfg_en_o <= (state_d == S_ACQUIRE) || (state_d == S_LOCKED);
      locked_o     <= (state_d == S_LOCKED);
      fault_o      <= (state_d == S_FAULT);
    end
  end

  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;

`ifdef SI571_PLL_SUPERVISOR_STATS_EN
  logic [15:0] lost_q;
  logic        lost_evt;

  assign lost_evt = (state_q == S_LOCKED) && (state_d == S_HOLDOFF);

  always_ff @(posedge clk_i) begin
    if (rst_i)                              lost_q <= '0;
    else if (lost_evt && lost_q != 16'hFFFF) lost_q <= lost_q + 16'd1;
  end

  assign lost_cnt_o = lost_q;
`endif

endmodule
